// File: rtl/gpio_debounce_pkg.sv
// Shared types and helpers for the GPIO input debounce slice.
package gpio_debounce_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_QUALIFY = 1'b1
  } db_state_e;

  // A programmed threshold of zero behaves exactly like one.
  function automatic logic [31:0] neff(input logic [31:0] n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/gpio_debounce_if.sv
// Pin/config inputs and filtered/event outputs of the debounce block.
interface gpio_debounce_if
  import gpio_debounce_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] pin_in;
  logic [CNT_W-1:0] debounce_cycles;
  logic [WIDTH-1:0] filt_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             any_edge;

  modport master (
    output pin_in, debounce_cycles,
    input  filt_out, rise_pulse, fall_pulse, any_edge
  );

  modport slave (
    input  pin_in, debounce_cycles,
    output filt_out, rise_pulse, fall_pulse, any_edge
  );

endinterface

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: two-flop synchroniser, consecutive-sample qualifier and edge pulses.
module gpio_debounce_bit
  import gpio_debounce_pkg::*;
#(
  parameter int   CNT_W   = DEF_CNT_W,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             pin_in,
  input  logic [CNT_W-1:0] debounce_cycles,
  output logic             filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             commit
);

  logic             sync0;
  logic             sync1;
  db_state_e        state;
  db_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             mismatch;
  logic             at_thresh;

  // Stage 0/1: metastability synchroniser
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= RST_VAL;
      sync1 <= RST_VAL;
    end else begin
      sync0 <= pin_in;
      sync1 <= sync0;
    end
  end

  assign mismatch  = (sync1 != filt);
  // Live threshold: lowering it mid-qualification commits on the next mismatch.
  assign at_thresh = ((32'(cnt) + 32'd1) >= neff(32'(debounce_cycles)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      DB_STABLE: begin
        if (mismatch) begin
          if (at_thresh) begin
            commit = 1'b1;
          end else begin
            state_nxt = DB_QUALIFY;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      DB_QUALIFY: begin
        if (!mismatch) begin
          state_nxt = DB_STABLE;
          cnt_nxt   = '0;
        end else if (at_thresh) begin
          commit    = 1'b1;
          state_nxt = DB_STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DB_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage 2: qualifier state, filtered level and one-cycle event pulses
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DB_STABLE;
      cnt        <= '0;
      filt       <= RST_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rise_pulse <= commit & sync1;
      fall_pulse <= commit & ~sync1;
      if (commit) begin
        filt <= sync1;
      end
    end
  end

endmodule

// File: rtl/gpio_debounce.sv
// GPIO input conditioning: per-bit debounce instances plus a combined edge flag.
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  gpio_debounce_if.slave bus
);

  logic [WIDTH-1:0] filt_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;
  logic [WIDTH-1:0] commit_v;
  logic             any_edge_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .CNT_W   (CNT_W),
      .RST_VAL (RST_VAL[i])
    ) u_bit (
      .sys_clk         (sys_clk),
      .rst_n           (rst_n),
      .pin_in          (bus.pin_in[i]),
      .debounce_cycles (bus.debounce_cycles),
      .filt            (filt_v[i]),
      .rise_pulse      (rise_v[i]),
      .fall_pulse      (fall_v[i]),
      .commit          (commit_v[i])
    );
  end

  // Stage 2: registered alongside the pulses, from the same commit strobes
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= |commit_v;
    end
  end

  assign bus.filt_out   = filt_v;
  assign bus.rise_pulse = rise_v;
  assign bus.fall_pulse = fall_v;
  assign bus.any_edge   = any_edge_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: two instances (reset value all-0 and all-1) checked against a sample-history model.
module tb_gpio_debounce;

  logic        sys_clk;
  logic        rst_n;
  logic [31:0] p0;
  logic [31:0] p1;
  logic [15:0] ncfg;
  int          checks;
  int          passes;

  gpio_debounce_if #(.WIDTH(32), .CNT_W(16)) bus0 ();
  gpio_debounce_if #(.WIDTH(32), .CNT_W(16)) bus1 ();

  assign bus0.pin_in          = p0;
  assign bus1.pin_in          = p1;
  assign bus0.debounce_cycles = ncfg;
  assign bus1.debounce_cycles = ncfg;

  gpio_debounce #(.WIDTH(32), .CNT_W(16), .RST_VAL(32'h0000_0000)) dut0 (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus0.slave)
  );

  gpio_debounce #(.WIDTH(32), .CNT_W(16), .RST_VAL(32'hFFFF_FFFF)) dut1 (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus1.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: filt takes the synchronised level once the last Neff samples all disagree with it.
  logic [31:0] m_s0   [2];
  logic [31:0] m_s1   [2];
  logic [31:0] m_filt [2];
  logic [31:0] m_rise [2];
  logic [31:0] m_fall [2];
  logic        m_any  [2];
  logic [63:0] hist   [$];

  wire [96:0] obs0 = {bus0.filt_out, bus0.rise_pulse, bus0.fall_pulse, bus0.any_edge};
  wire [96:0] obs1 = {bus1.filt_out, bus1.rise_pulse, bus1.fall_pulse, bus1.any_edge};
  wire [96:0] exp0 = {m_filt[0], m_rise[0], m_fall[0], m_any[0]};
  wire [96:0] exp1 = {m_filt[1], m_rise[1], m_fall[1], m_any[1]};

  task automatic model_reset();
    m_s0[0] = 32'h0;  m_s1[0] = 32'h0;  m_filt[0] = 32'h0;
    m_s0[1] = '1;     m_s1[1] = '1;     m_filt[1] = '1;
    for (int k = 0; k < 2; k++) begin
      m_rise[k] = '0; m_fall[k] = '0; m_any[k] = 1'b0;
    end
    hist.delete();
  endtask

  task automatic model_step();
    int          ne;
    logic [63:0] e;
    logic [31:0] mm;
    logic [31:0] s_old;
    ne = (ncfg == 16'd0) ? 1 : int'(ncfg);
    hist.push_back({m_s1[1], m_s1[0]});
    if (hist.size() > 1100) void'(hist.pop_front());
    for (int k = 0; k < 2; k++) begin
      s_old = m_s1[k];
      mm    = '1;
      if (hist.size() < ne) mm = '0;
      else begin
        for (int j = 0; j < ne; j++) begin
          e  = hist[hist.size() - 1 - j];
          mm = mm & (e[k*32 +: 32] ^ m_filt[k]);
          if (mm == 32'h0) break;
        end
      end
      m_rise[k] = mm & s_old;
      m_fall[k] = mm & ~s_old;
      m_any[k]  = |mm;
      m_filt[k] = (m_filt[k] & ~mm) | (s_old & mm);
      m_s1[k]   = m_s0[k];
      m_s0[k]   = (k == 0) ? p0 : p1;
    end
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  task automatic assert_reset();
    @(posedge sys_clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge sys_clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ncfg = 16'd4;
    p0   = 32'h0;
    p1   = '1;
    assert_reset();
    checks++;
    if (bus0.filt_out !== 32'h0 || bus1.filt_out !== 32'hFFFF_FFFF ||
        (bus0.rise_pulse | bus0.fall_pulse | bus1.rise_pulse | bus1.fall_pulse) !== 32'h0 ||
        bus0.any_edge !== 1'b0 || bus1.any_edge !== 1'b0)
      $display("FAIL reset_state: got %h / %h want filt 0 / ffffffff, no pulses", obs0, obs1);
    else passes++;
    release_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1)
        $display("FAIL reset_idle cyc%0d: got %h %h want %h %h", i, obs0, obs1, exp0, exp1);
      else passes++;
    end
  endtask

  task automatic test_rise_latency();
    int hit;
    int npulse;
    hit = -1; npulse = 0;
    ncfg = 16'd4;
    p0[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1)
        $display("FAIL rise_model cyc%0d: got %h %h want %h %h", i, obs0, obs1, exp0, exp1);
      else passes++;
      if (bus0.rise_pulse !== 32'h0) npulse++;
      if (bus0.rise_pulse === 32'h8 && bus0.any_edge === 1'b1 && bus0.filt_out[3] === 1'b1 && hit < 0)
        hit = i;
    end
    checks++;
    if (hit !== 5 || npulse !== 1)
      $display("FAIL rise_latency: pulse at cycle %0d lasting %0d, want cycle 5 lasting 1", hit, npulse);
    else passes++;
  endtask

  task automatic test_glitch();
    int seen;
    seen = 0;
    ncfg = 16'd4;
    p0[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) p0[0] = 1'b0;
      cycle();
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1)
        $display("FAIL glitch_model cyc%0d: got %h %h want %h %h", i, obs0, obs1, exp0, exp1);
      else passes++;
      if (bus0.filt_out[0] !== 1'b0 || bus0.rise_pulse !== 32'h0 || bus0.any_edge !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL glitch_reject: %0d cycles showed activity, want 0", seen);
    else passes++;
  endtask

  task automatic test_n0_vs_n1();
    int hit;
    for (int n = 0; n < 2; n++) begin
      hit  = -1;
      ncfg = 16'(n);
      p0[1] = ~p0[1];
      for (int i = 0; i < 6; i++) begin
        cycle();
        checks++;
        if (obs0 !== exp0 || obs1 !== exp1)
          $display("FAIL n01_model n%0d cyc%0d: got %h %h want %h %h", n, i, obs0, obs1, exp0, exp1);
        else passes++;
        if (((bus0.rise_pulse | bus0.fall_pulse) === 32'h2) && hit < 0) hit = i;
      end
      checks++;
      if (hit !== 2) $display("FAIL n01_latency n%0d: commit at cycle %0d, want 2", n, hit);
      else passes++;
    end
  endtask

  task automatic test_simultaneous();
    int hit;
    hit  = -1;
    ncfg = 16'd10;
    p0[0]  = 1'b1;
    p0[31] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1)
        $display("FAIL simul_model cyc%0d: got %h %h want %h %h", i, obs0, obs1, exp0, exp1);
      else passes++;
      if (bus0.rise_pulse === 32'h8000_0001 && hit < 0) hit = i;
    end
    checks++;
    if (hit !== 11) $display("FAIL simul_commit: both bits at cycle %0d, want 11", hit);
    else passes++;
  endtask

  task automatic test_live_threshold();
    int hit;
    int bad;
    hit = -1; bad = 0;
    ncfg = 16'd1000;
    p0[5] = 1'b1;
    for (int i = 0; i < 205; i++) begin
      if (i == 202) ncfg = 16'd50;
      cycle();
      if (obs0 !== exp0 || obs1 !== exp1) bad++;
      if (bus0.rise_pulse === 32'h20 && hit < 0) hit = i;
    end
    checks++;
    if (bad !== 0 || hit !== 202)
      $display("FAIL live_lower: %0d model diffs, commit at cycle %0d, want 0 and 202", bad, hit);
    else passes++;
    hit = -1;
    p0[5] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1)
        $display("FAIL live_model cyc%0d: got %h %h want %h %h", i, obs0, obs1, exp0, exp1);
      else passes++;
      if (bus0.fall_pulse === 32'h20 && hit < 0) hit = i;
    end
    checks++;
    if (hit !== 51) $display("FAIL live_restart: fall at cycle %0d, want 51", hit);
    else passes++;
  endtask

  task automatic test_rstval_ones();
    int hit;
    int other;
    hit = -1; other = 0;
    ncfg = 16'd8;
    p1[7] = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 8) p1[7] = 1'b1;
      cycle();
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1)
        $display("FAIL ones_model cyc%0d: got %h %h want %h %h", i, obs0, obs1, exp0, exp1);
      else passes++;
      if (bus1.fall_pulse === 32'h80 && hit < 0) hit = i;
      if ((bus1.fall_pulse & ~32'h80) !== 32'h0) other++;
    end
    checks++;
    if (hit !== 9 || other !== 0)
      $display("FAIL ones_fall: fall 0x80 at cycle %0d, stray %0d, want 9 and 0", hit, other);
    else passes++;
  endtask

  task automatic test_reset_midqualify();
    ncfg = 16'd8;
    p1[9] = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    assert_reset();
    checks++;
    if (bus1.filt_out !== 32'hFFFF_FFFF || bus1.fall_pulse !== 32'h0 || bus1.any_edge !== 1'b0 ||
        bus0.filt_out !== 32'h0)
      $display("FAIL midq_reset: got %h / %h want filt ffffffff / 0, no pulses", obs1, obs0);
    else passes++;
    p1[9] = 1'b1;
    release_reset();
    for (int i = 0; i < 14; i++) begin
      cycle();
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1)
        $display("FAIL midq_model cyc%0d: got %h %h want %h %h", i, obs0, obs1, exp0, exp1);
      else passes++;
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) ncfg = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) p0 = p0 ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) p1 = p1 ^ ($urandom & $urandom & $urandom);
      cycle();
      checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        bad++;
        if (bad < 10)
          $display("FAIL random cyc%0d: got %h %h want %h %h", i, obs0, obs1, exp0, exp1);
      end else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b1;
    p0     = 32'h0;
    p1     = '1;
    ncfg   = 16'd4;
    model_reset();
    test_reset();
    test_rise_latency();
    test_glitch();
    test_n0_vs_n1();
    test_simultaneous();
    test_live_threshold();
    test_rstval_ones();
    test_reset_midqualify();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
# gpio_debounce

Per-bit input conditioning stage between the board GPIO pins and the GPIO controller's input-status register. Synchronises each raw pin into `sys_clk` and applies a programmable consecutive-sample debounce filter. Presents a glitch-free filtered vector plus single-cycle rise/fall event pulses, which downstream logic uses as interrupt sources. The filtered vector drives the controller's `gpio_in` directly. The controller's own two-flop synchroniser then adds 2 cycles of benign latency.

## Interface
- `WIDTH`, default 32: number of GPIO bits
- `CNT_W`, default 16: width of the debounce threshold and of each per-bit counter
- `RST_VAL`, default `'0`: reset value of the filtered vector, `WIDTH` bits

- `sys_clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pin_in`  in  WIDTH  raw asynchronous pin levels
- `debounce_cycles`  in  CNT_W  threshold N, quasi-static config; value 0 is treated as 1
- `filt_out`  out  WIDTH  debounced level, registered
- `rise_pulse`  out  WIDTH  one-cycle pulse when a bit of `filt_out` goes 0→1
- `fall_pulse`  out  WIDTH  one-cycle pulse when a bit of `filt_out` goes 1→0
- `any_edge`  out  1  registered OR of all bits of `rise_pulse | fall_pulse`, in the same cycle as the pulses

## Operation
- Per bit i, a two-flop synchroniser produces `s[i]` from `pin_in[i]` (`sync0` feeds `sync1`). Both flops reset to `RST_VAL[i]`.
- Let Neff = max(`debounce_cycles`, 1).
- Per-bit FSM with two states, STABLE and QUALIFY:
  - STABLE: counter is 0. On an edge where `s != filt`, go to QUALIFY with cnt=1. If Neff==1, instead commit immediately (see commit rule) and stay in STABLE.
  - QUALIFY, `s == filt`: cnt←0, go to STABLE. A glitch shorter than Neff is fully rejected.
  - QUALIFY, `s != filt` and cnt+1 ≥ Neff: commit and go to STABLE with cnt←0.
  - QUALIFY, `s != filt` otherwise: cnt←cnt+1.
- Commit rule: `filt←s`; the matching rise or fall pulse is asserted for the next cycle only.
- The threshold comparison uses the live `debounce_cycles`. If N is lowered mid-QUALIFY so that cnt+1 ≥ Neff, the bit commits on the next mismatch edge.
- The counter never exceeds Neff, so it cannot wrap.
- Bits are fully independent; simultaneous commits on several bits are legal and each bit pulses.
- Rise and fall are mutually exclusive per bit per cycle.
- If `RST_VAL[i]`=0 and the pin is held high through reset, the bit produces one rise pulse after release. This is intended.

## Timing
- Reset: `filt_out`=`RST_VAL`, `rise_pulse`=0, `fall_pulse`=0, `any_edge`=0, all FSMs in STABLE, all counters 0, synchronisers=`RST_VAL`.
- Let pin i change, stably, before edge E0.
  - `s[i]` changes after E1.
  - The first mismatch edge is E2.
  - `filt_out[i]`, `rise_pulse`/`fall_pulse` and `any_edge` all change after edge E(1+Neff), so latency is Neff+1 cycles after the capture edge E0.
  - The pulses deassert after E(2+Neff).
- Steady-state toggling requires each level to persist at least Neff cycles at `s`. Otherwise `filt_out` does not change.
- An asynchronous reset asserted mid-QUALIFY aborts the qualification with no pulse. The bit restarts from `RST_VAL`.

## Structure
- Package `gpio_debounce_pkg`:
  - `db_state_e` enum {`DB_STABLE`, `DB_QUALIFY`}
  - `localparam` default `CNT_W`
  - helper function `neff(n)` returning max(n,1)
- Sub-module `gpio_debounce_bit`: one synchroniser, FSM, counter and pulse generator, parameterised by `CNT_W`.
- Top: a generate loop over `WIDTH` instances plus the registered `any_edge` OR-reduction.

## Test plan
- Reset with `pin_in`=0, `RST_VAL`=0, N=4; raise `pin_in[3]` before E0 → `filt_out[3]`=1 and `rise_pulse`=0x8 appear after E5; the pulse lasts exactly 1 cycle; `any_edge`=1 in that same cycle.
- N=4; 3-cycle high glitch on `pin_in[0]` → `filt_out`, `rise_pulse` and `any_edge` stay 0 throughout.
- N=0 versus N=1: identical 1-cycle qualification; a pin change before E0 → commit after E2.
- N=10; raise bits 0 and 31 on the same edge → both commit in the same cycle; `rise_pulse`=0x80000001.
- N=1000 with bit 5 mid-QUALIFY at cnt=200; set N=50 → commit on the next mismatch edge; counter back to 0.
- `RST_VAL`=0xFFFFFFFF, pins all 1 → no pulses after reset. Then drop bit 7 for N cycles → `fall_pulse`=0x80. Assert `rst_n` mid-QUALIFY on another bit → no pulse and immediate return to `RST_VAL`.
